// File: rtl/ast_tensor_dma_port_sv.sv
// Tensor-side DMA streaming responder: operand buffers A/B, result buffer readout, MXU side port.
// Optional macro ASTTDP_ZERO_PAD_EN clears target-buffer entries outside the load window at load start.
module ast_tensor_dma_port_sv #(
    parameter int SIZE      = 4,
    parameter int DATAWIDTH = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATAWIDTH-1:0]     depth,
    input  logic [DATAWIDTH-1:0]     width,
    input  logic [1:0]               set,
    input  logic                     wen,
    input  logic                     ren,
    input  logic [DATAWIDTH-1:0]     data_in,
    input  logic                     relu,
    output logic [DATAWIDTH-1:0]     data_out,
    input  logic                     mxu_sel,
    input  logic [$clog2(SIZE)-1:0]  mxu_row,
    input  logic [$clog2(SIZE)-1:0]  mxu_col,
    output logic [DATAWIDTH-1:0]     mxu_rdata,
    input  logic                     res_wen,
    input  logic [$clog2(SIZE)-1:0]  res_row,
    input  logic [$clog2(SIZE)-1:0]  res_col,
    input  logic [DATAWIDTH-1:0]     res_data,
    output logic                     busy,
    output logic                     load_done,
    output logic                     unload_done,
    output logic                     err
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;

`ifdef ASTTDP_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_UNLOAD} state_t;

    function automatic logic [CW-1:0] clamp_dim(input logic [DATAWIDTH-1:0] v);
        if (v == DATAWIDTH'(0))         clamp_dim = CW'(1);
        else if (v > DATAWIDTH'(SIZE))  clamp_dim = CW'(SIZE);
        else                            clamp_dim = v[CW-1:0];
    endfunction

    function automatic logic bad_dim(input logic [DATAWIDTH-1:0] v);
        bad_dim = (v == DATAWIDTH'(0)) || (v > DATAWIDTH'(SIZE));
    endfunction

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [CW-1:0]         dep_q, dep_d, wid_q, wid_d;
    logic [AW-1:0]         row_q, row_d, col_q, col_d;
    logic                  err_q, err_d;
    logic                  load_done_q, load_done_d;
    logic                  unload_done_q, unload_done_d;
    logic                  busy_q;
    logic [DATAWIDTH-1:0]  data_out_q, data_out_d;
    logic [DATAWIDTH-1:0]  op_q  [2][SIZE][SIZE];
    logic [DATAWIDTH-1:0]  res_q [SIZE][SIZE];

    logic [CW-1:0]         start_dep_s, start_wid_s, cur_dep_s, cur_wid_s;
    logic                  clamp_err_s, last_col_s, last_s;
    logic [AW-1:0]         adv_row_s, adv_col_s;
    logic                  op_we_s, op_sel_s, pad_s;
    logic [DATAWIDTH-1:0]  res_view_s;

    // Transfer geometry: in IDLE the live (clamped) inputs describe the transfer being started.
    always_comb begin
        start_dep_s = clamp_dim(depth);
        start_wid_s = clamp_dim(width);
        clamp_err_s = bad_dim(depth) | bad_dim(width);
        if (state_q == ST_IDLE) begin
            cur_dep_s = start_dep_s;
            cur_wid_s = start_wid_s;
        end else begin
            cur_dep_s = dep_q;
            cur_wid_s = wid_q;
        end
        last_col_s = ({1'b0, col_q} == cur_wid_s - CW'(1));
        last_s     = last_col_s && ({1'b0, row_q} == cur_dep_s - CW'(1));
        if (last_col_s) begin
            adv_row_s = row_q + AW'(1);
            adv_col_s = AW'(0);
        end else begin
            adv_row_s = row_q;
            adv_col_s = col_q + AW'(1);
        end
    end

    // Next-state and control decode for the IDLE/LOAD/UNLOAD protocol FSM.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        dep_d         = dep_q;
        wid_d         = wid_q;
        row_d         = row_q;
        col_d         = col_q;
        err_d         = err_q;
        load_done_d   = 1'b0;
        unload_done_d = 1'b0;
        op_we_s       = 1'b0;
        op_sel_s      = sel_q;
        pad_s         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wen) begin
                    if (!set[1]) begin
                        sel_d    = set[0];
                        dep_d    = start_dep_s;
                        wid_d    = start_wid_s;
                        err_d    = clamp_err_s | ren;
                        op_we_s  = 1'b1;
                        op_sel_s = set[0];
                        pad_s    = 1'b1;
                        if (last_s) begin
                            load_done_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                            row_d   = adv_row_s;
                            col_d   = adv_col_s;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ren) begin
                    if (set == 2'd2) begin
                        sel_d = set[0];
                        dep_d = start_dep_s;
                        wid_d = start_wid_s;
                        err_d = clamp_err_s;
                        if (last_s) begin
                            unload_done_d = 1'b1;
                        end else begin
                            state_d = ST_UNLOAD;
                            row_d   = adv_row_s;
                            col_d   = adv_col_s;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ren) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (wen) begin
                    op_we_s = 1'b1;
                    if (last_s) begin
                        state_d     = ST_IDLE;
                        row_d       = AW'(0);
                        col_d       = AW'(0);
                        load_done_d = 1'b1;
                    end else begin
                        row_d = adv_row_s;
                        col_d = adv_col_s;
                    end
                end else begin
                    op_we_s = 1'b0;
                end
            end
            ST_UNLOAD: begin
                if (wen) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (ren) begin
                    if (last_s) begin
                        state_d       = ST_IDLE;
                        row_d         = AW'(0);
                        col_d         = AW'(0);
                        unload_done_d = 1'b1;
                    end else begin
                        row_d = adv_row_s;
                        col_d = adv_col_s;
                    end
                end else begin
                    unload_done_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = AW'(0);
                col_d   = AW'(0);
            end
        endcase
    end

    // Readout view: forward a same-cycle result write to the element about to be shown.
    always_comb begin
        if (res_wen && (res_row == row_d) && (res_col == col_d)) begin
            res_view_s = res_data;
        end else begin
            res_view_s = res_q[row_d][col_d];
        end
        if (relu && res_view_s[DATAWIDTH-1]) begin
            data_out_d = DATAWIDTH'(0);
        end else begin
            data_out_d = res_view_s;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            dep_q         <= CW'(1);
            wid_q         <= CW'(1);
            row_q         <= AW'(0);
            col_q         <= AW'(0);
            err_q         <= 1'b0;
            load_done_q   <= 1'b0;
            unload_done_q <= 1'b0;
            busy_q        <= 1'b0;
            data_out_q    <= DATAWIDTH'(0);
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            dep_q         <= dep_d;
            wid_q         <= wid_d;
            row_q         <= row_d;
            col_q         <= col_d;
            err_q         <= err_d;
            load_done_q   <= load_done_d;
            unload_done_q <= unload_done_d;
            busy_q        <= (state_d != ST_IDLE);
            data_out_q    <= data_out_d;
        end
    end

    // Operand buffers; the stream write follows the padding clear so it always lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < SIZE; i++)
                    for (int j = 0; j < SIZE; j++)
                        op_q[s][i][j] <= DATAWIDTH'(0);
        end else begin
            if (PAD_EN && pad_s) begin
                for (int i = 0; i < SIZE; i++)
                    for (int j = 0; j < SIZE; j++)
                        if ((i >= int'(dep_d)) || (j >= int'(wid_d)))
                            op_q[op_sel_s][i][j] <= DATAWIDTH'(0);
            end
            if (op_we_s) begin
                op_q[op_sel_s][row_q][col_q] <= data_in;
            end
        end
    end

    // Result buffer written by the MXU in any state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++)
                    res_q[i][j] <= DATAWIDTH'(0);
        end else if (res_wen) begin
            res_q[res_row][res_col] <= res_data;
        end
    end

    assign data_out    = data_out_q;
    assign mxu_rdata   = op_q[mxu_sel][mxu_row][mxu_col];
    assign busy        = busy_q;
    assign load_done   = load_done_q;
    assign unload_done = unload_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ast_tensor_dma_port_sv.sv
// Self-checking bench for ast_tensor_dma_port_sv: vector table, directed corner sequences,
// and randomized traffic against a queue-based transfer model.
module tb_ast_tensor_dma_port_sv;
    localparam int SIZE = 4;
    localparam int DW   = 14;
    localparam int AW   = 2;

`ifdef ASTTDP_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] depth, width, data_in, res_data, data_out, mxu_rdata;
    logic [1:0]    set;
    logic          wen, ren, relu, mxu_sel, res_wen;
    logic [AW-1:0] mxu_row, mxu_col, res_row, res_col;
    logic          busy, load_done, unload_done, err;

    int n_checks = 0;
    int n_pass   = 0;

    ast_tensor_dma_port_sv #(.SIZE(SIZE), .DATAWIDTH(DW)) dut (
        .clk(clk), .reset(reset), .depth(depth), .width(width), .set(set),
        .wen(wen), .ren(ren), .data_in(data_in), .relu(relu), .data_out(data_out),
        .mxu_sel(mxu_sel), .mxu_row(mxu_row), .mxu_col(mxu_col), .mxu_rdata(mxu_rdata),
        .res_wen(res_wen), .res_row(res_row), .res_col(res_col), .res_data(res_data),
        .busy(busy), .load_done(load_done), .unload_done(unload_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wen;
        logic [DW-1:0] din;
        logic [AW-1:0] rr, rc;
        logic          e_busy, e_ld;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input logic w, input int din, input int rr, input int rc,
                                input logic eb, input logic el, input int erd);
        vec_t v;
        v.wen = w; v.din = DW'(din); v.rr = AW'(rr); v.rc = AW'(rc);
        v.e_busy = eb; v.e_ld = el; v.e_rd = DW'(erd);
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wen = 1'b0; ren = 1'b0; res_wen = 1'b0;
    endtask

    task automatic load_seq(input int s, input int d, input int w, input int base, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            wen = 1'b1; set = 2'(s); depth = DW'(d); width = DW'(w); data_in = DW'(base + step * i);
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic peek(input string name, input int s, input int r, input int c, input int exp);
        mxu_sel = s[0]; mxu_row = AW'(r); mxu_col = AW'(c);
        #1;
        check(name, mxu_rdata, DW'(exp));
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mA [2][SIZE][SIZE];
    logic [DW-1:0] mR [SIZE][SIZE];
    int  m_mode;     // 0 idle, 1 loading, 2 reading out
    int  q[$];       // remaining element positions r*SIZE+c, row-major
    bit  m_sel, m_err, m_ld, m_ul;

    function automatic int clampv(input int v);
        if (v == 0) return 1;
        if (v > SIZE) return SIZE;
        return v;
    endfunction

    function automatic bit badv(input int v);
        return (v == 0) || (v > SIZE);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++) mA[s][r][c] = '0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) mR[r][c] = '0;
        m_mode = 0; q.delete(); m_sel = 1'b0; m_err = 1'b0; m_ld = 1'b0; m_ul = 1'b0;
    endtask

    task automatic model_begin(input int d, input int w);
        q.delete();
        for (int r = 0; r < d; r++)
            for (int c = 0; c < w; c++) q.push_back(r * SIZE + c);
    endtask

    task automatic model_step();
        int p, d, w;
        m_ld = 1'b0; m_ul = 1'b0;
        d = clampv(int'(depth)); w = clampv(int'(width));
        if (m_mode == 0) begin
            if (wen) begin
                if (set < 2'd2) begin
                    m_sel = set[0];
                    m_err = badv(int'(depth)) | badv(int'(width)) | ren;
                    model_begin(d, w);
                    if (PAD)
                        for (int r = 0; r < SIZE; r++)
                            for (int c = 0; c < SIZE; c++)
                                if (r >= d || c >= w) mA[m_sel][r][c] = '0;
                    p = q.pop_front();
                    mA[m_sel][p / SIZE][p % SIZE] = data_in;
                    if (q.size() == 0) m_ld = 1'b1; else m_mode = 1;
                end else m_err = 1'b1;
            end else if (ren) begin
                if (set == 2'd2) begin
                    m_err = badv(int'(depth)) | badv(int'(width));
                    model_begin(d, w);
                    p = q.pop_front();
                    if (q.size() == 0) m_ul = 1'b1; else m_mode = 2;
                end else m_err = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (ren) m_err = 1'b1;
            if (wen) begin
                p = q.pop_front();
                mA[m_sel][p / SIZE][p % SIZE] = data_in;
                if (q.size() == 0) begin m_mode = 0; m_ld = 1'b1; end
            end
        end else begin
            if (wen) m_err = 1'b1;
            if (ren) begin
                p = q.pop_front();
                if (q.size() == 0) begin m_mode = 0; m_ul = 1'b1; end
            end
        end
        if (res_wen) mR[res_row][res_col] = res_data;
    endtask

    function automatic logic [DW-1:0] model_dout();
        int p;
        logic [DW-1:0] v;
        p = (m_mode != 0) ? q[0] : 0;
        v = mR[p / SIZE][p % SIZE];
        return (relu && v[DW-1]) ? DW'(0) : v;
    endfunction

    initial begin
        quiet();
        set = 2'd0; depth = DW'(4); width = DW'(4); data_in = '0; relu = 1'b0;
        mxu_sel = 1'b0; mxu_row = '0; mxu_col = '0; res_row = '0; res_col = '0; res_data = '0;
        reset = 1'b1;
        #1;
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_load_done", DW'(load_done), DW'(0));
        check("rst_unload_done", DW'(unload_done), DW'(0));
        check("rst_err", DW'(err), DW'(0));
        check("rst_data_out", data_out, DW'(0));
        check("rst_rdata", mxu_rdata, DW'(0));
        tick();
        reset = 1'b0;
        tick();

        // 4x4 load of A with values 1..16
        for (int k = 0; k < 16; k++) vt[k] = mk(1'b1, k + 1, k / 4, k % 4, k < 15, k == 15, k + 1);
        vt[16] = mk(1'b0, 0, 2, 3, 1'b0, 1'b0, 12);
        vt[17] = mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1);
        for (int k = 0; k < 18; k++) begin
            wen = vt[k].wen; set = 2'd0; depth = DW'(4); width = DW'(4); data_in = vt[k].din;
            mxu_sel = 1'b0; mxu_row = vt[k].rr; mxu_col = vt[k].rc;
            tick();
            check($sformatf("vecA_busy[%0d]", k), DW'(busy), DW'(vt[k].e_busy));
            check($sformatf("vecA_load_done[%0d]", k), DW'(load_done), DW'(vt[k].e_ld));
            check($sformatf("vecA_rdata[%0d]", k), mxu_rdata, vt[k].e_rd);
            check($sformatf("vecA_err[%0d]", k), DW'(err), DW'(0));
        end

        // B prefilled with 7, then 2x3 load with 5..10
        load_seq(1, 4, 4, 7, 0, 16);
        check("B_fill_done", DW'(load_done), DW'(1));
        load_seq(1, 2, 3, 5, 1, 6);
        check("B_load_done", DW'(load_done), DW'(1));
        peek("B_1_2", 1, 1, 2, 10);
        peek("B_0_0", 1, 0, 0, 5);
        peek("B_3_3", 1, 3, 3, PAD ? 0 : 7);
        peek("B_0_3", 1, 0, 3, PAD ? 0 : 7);
        peek("A_untouched", 0, 3, 3, 16);

        // result readout with and without ReLU
        res_wen = 1'b1; res_row = 2'd0; res_col = 2'd0; res_data = DW'(-3);
        tick();
        res_col = 2'd1; res_data = DW'(9);
        tick();
        res_wen = 1'b0;
        for (int rl = 0; rl < 2; rl++) begin
            relu = rl[0];
            tick();
            check($sformatf("ro%0d_first", rl), data_out, rl ? DW'(0) : DW'(-3));
            ren = 1'b1; set = 2'd2; depth = DW'(1); width = DW'(2);
            tick();
            check($sformatf("ro%0d_second", rl), data_out, DW'(9));
            check($sformatf("ro%0d_busy", rl), DW'(busy), DW'(1));
            check($sformatf("ro%0d_early_done", rl), DW'(unload_done), DW'(0));
            tick();
            ren = 1'b0;
            check($sformatf("ro%0d_done", rl), DW'(unload_done), DW'(1));
            check($sformatf("ro%0d_idle_busy", rl), DW'(busy), DW'(0));
            check($sformatf("ro%0d_wrap", rl), data_out, rl ? DW'(0) : DW'(-3));
            tick();
            check($sformatf("ro%0d_done_pulse", rl), DW'(unload_done), DW'(0));
        end
        relu = 1'b0;

        // clamped start: depth 6 -> 4, width 0 -> 1
        load_seq(0, 6, 0, 31, 1, 1);
        check("clamp_err", DW'(err), DW'(1));
        check("clamp_busy", DW'(busy), DW'(1));
        load_seq(0, 1, 1, 32, 1, 2);
        check("clamp_busy3", DW'(busy), DW'(1));
        load_seq(0, 1, 1, 34, 1, 1);
        check("clamp_done", DW'(load_done), DW'(1));
        check("clamp_err_sticky", DW'(err), DW'(1));
        peek("clamp_3_0", 0, 3, 0, 34);
        peek("clamp_1_0", 0, 1, 0, 32);
        peek("clamp_0_1", 0, 0, 1, 2);
        tick();
        check("clamp_err_idle", DW'(err), DW'(1));
        load_seq(0, 1, 1, 40, 1, 1);
        check("valid_clears_err", DW'(err), DW'(0));
        check("1x1_done", DW'(load_done), DW'(1));
        check("1x1_busy", DW'(busy), DW'(0));

        // wen+ren together in IDLE, then a stray ren in LOAD
        wen = 1'b1; ren = 1'b1; set = 2'd0; depth = DW'(2); width = DW'(2); data_in = DW'(21);
        tick();
        check("both_err", DW'(err), DW'(1));
        check("both_busy", DW'(busy), DW'(1));
        wen = 1'b0;
        tick();
        ren = 1'b0;
        check("stray_ren_busy", DW'(busy), DW'(1));
        load_seq(0, 2, 2, 22, 1, 3);
        check("both_done", DW'(load_done), DW'(1));
        peek("both_0_0", 0, 0, 0, 21);
        peek("both_0_1", 0, 0, 1, 22);
        peek("both_1_0", 0, 1, 0, 23);
        peek("both_1_1", 0, 1, 1, 24);

        // reset in the middle of a 4x4 load
        load_seq(0, 4, 4, 50, 1, 7);
        check("mid_busy", DW'(busy), DW'(1));
        reset = 1'b1;
        #1;
        check("ab_busy", DW'(busy), DW'(0));
        check("ab_err", DW'(err), DW'(0));
        check("ab_load_done", DW'(load_done), DW'(0));
        check("ab_unload_done", DW'(unload_done), DW'(0));
        check("ab_data_out", data_out, DW'(0));
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    peek($sformatf("ab_buf[%0d][%0d][%0d]", s, r, c), s, r, c, 0);
        tick();
        reset = 1'b0;
        tick();
        check("ab_no_done", DW'(load_done), DW'(0));
        check("ab_idle", DW'(busy), DW'(0));

        // randomized traffic against the model
        model_reset();
        for (int n = 0; n < 800; n++) begin
            wen      = ($urandom_range(0, 99) < 45);
            ren      = ($urandom_range(0, 99) < 35);
            set      = 2'($urandom_range(0, 3));
            depth    = DW'($urandom_range(0, 5));
            width    = DW'($urandom_range(0, 5));
            data_in  = DW'($urandom);
            relu     = ($urandom_range(0, 3) == 0);
            res_wen  = ($urandom_range(0, 99) < 40);
            res_row  = AW'($urandom_range(0, 3));
            res_col  = AW'($urandom_range(0, 3));
            res_data = DW'($urandom);
            mxu_sel  = ($urandom_range(0, 1) == 1);
            mxu_row  = AW'($urandom_range(0, 3));
            mxu_col  = AW'($urandom_range(0, 3));
            model_step();
            tick();
            check("rnd_busy", DW'(busy), DW'(m_mode != 0));
            check("rnd_load_done", DW'(load_done), DW'(m_ld));
            check("rnd_unload_done", DW'(unload_done), DW'(m_ul));
            check("rnd_err", DW'(err), DW'(m_err));
            check("rnd_data_out", data_out, model_dout());
            check("rnd_rdata", mxu_rdata, mA[mxu_sel][mxu_row][mxu_col]);
        end
        quiet();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
